// File: rtl/aes_pkg.sv
// aes_pkg: shared AES state type and ShiftRows byte maps for the final-round stage.
package aes_pkg;
  typedef logic [127:0] aes_state_t;
  localparam int AES_BYTES = 16;
  // Output byte index -> source byte index; byte 0 is the most significant byte.
  localparam int SHIFTROWS_MAP [AES_BYTES] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
  localparam int INV_SHIFTROWS_MAP [AES_BYTES] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
endpackage

// File: rtl/aes_shiftrows_comb.sv
// aes_shiftrows_comb: combinational ShiftRows byte permutation.
// AES_INV_SHIFTROWS_EN adds an inv input selecting InvShiftRows.
module aes_shiftrows_comb
  import aes_pkg::*;
(
`ifdef AES_INV_SHIFTROWS_EN
  input  logic         inv,
`endif
  input  logic [127:0] d,
  output logic [127:0] q
);
  for (genvar i = 0; i < AES_BYTES; i++) begin : g_b
`ifdef AES_INV_SHIFTROWS_EN
    assign q[127-8*i -: 8] = inv ? d[127-8*INV_SHIFTROWS_MAP[i] -: 8] : d[127-8*SHIFTROWS_MAP[i] -: 8];
`else
    assign q[127-8*i -: 8] = d[127-8*SHIFTROWS_MAP[i] -: 8];
`endif
  end
endmodule

// File: rtl/aes_final_round_stage.sv
// aes_final_round_stage: two-stage back-pressurable ShiftRows + AddRoundKey pipeline.
// AES_INV_SHIFTROWS_EN adds an inv input selecting InvShiftRows per block.
module aes_final_round_stage
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         iready,
`ifdef AES_INV_SHIFTROWS_EN
  input  logic         inv,
`endif
  input  logic [127:0] data,
  input  logic [127:0] round_key,
  output logic         oready,
  input  logic         out_ready,
  output logic [127:0] result
);
  logic       s1_valid, s2_valid, s2_load;
  aes_state_t s1_state, s1_key, s2_state, shifted;
  aes_shiftrows_comb u_sr (
`ifdef AES_INV_SHIFTROWS_EN
    .inv(inv),
`endif
    .d(data),
    .q(shifted)
  );
  // Each stage loads when empty or when its content moves forward this cycle.
  assign s2_load = !s2_valid || out_ready;
  assign iready  = !s1_valid || s2_load;
  assign oready  = s2_valid;
  assign result  = s2_state;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_state <= '0;
      s1_key   <= '0;
      s2_state <= '0;
    end else begin
      if (iready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_state <= shifted;
          s1_key   <= round_key;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_state <= s1_state ^ s1_key;
      end
    end
  end
endmodule

// File: tb/tb_aes_final_round_stage.sv
// tb_aes_final_round_stage: randomized scoreboard bench for the AES final-round stage.
// Exercises inverse ShiftRows too when built with AES_INV_SHIFTROWS_EN.
module tb_aes_final_round_stage;
  logic         clk = 0;
  logic         reset_n = 0;
  logic         in_valid = 0;
  logic         iready;
  logic         inv_r = 0;
  logic [127:0] data = '0;
  logic [127:0] round_key = '0;
  logic         oready;
  logic         out_ready = 0;
  logic [127:0] result;

  int tests = 0;
  int fails = 0;
  int n_acc = 0;
  int n_out = 0;
  logic [127:0] q[$];
  logic         held = 0;
  logic [127:0] held_val = '0;

  aes_final_round_stage dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .iready(iready),
`ifdef AES_INV_SHIFTROWS_EN
    .inv(inv_r),
`endif
    .data(data),
    .round_key(round_key),
    .oready(oready),
    .out_ready(out_ready),
    .result(result)
  );

  always #5 clk = ~clk;

  // Row r of the state is rotated left by r columns (right by r for the inverse).
  function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k, input logic iv);
    logic [127:0] s;
    int src;
    s = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        src = r + 4 * (iv ? (c - r + 4) % 4 : (c + r) % 4);
        s[127-8*(r+4*c) -: 8] = d[127-8*src -: 8];
      end
    return s ^ k;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Capacity of the stage is two blocks; handshakes are resolved here, mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (held) begin
        chk("stall_oready", {127'b0, oready}, 128'd1);
        chk("stall_result", result, held_val);
      end
      chk("iready", {127'b0, iready}, {127'b0, (q.size() < 2) || out_ready});
      if (oready && q.size() == 0) chk("spurious_oready", {127'b0, oready}, 128'd0);
      if (oready && out_ready && q.size() > 0) begin
        chk("result", result, q.pop_front());
        n_out++;
      end
      if (in_valid && iready) begin
        q.push_back(model(data, round_key, inv_r));
        n_acc++;
      end
      held = oready && !out_ready;
      held_val = result;
    end else held = 0;
  end

  task automatic directed(input string name, input logic [127:0] d, input logic [127:0] k,
                          input logic iv, input logic [127:0] exp);
    chk({name, "_model"}, model(d, k, iv), exp);
    chk({name, "_iready"}, {127'b0, iready}, 128'd1);
    in_valid = 1; data = d; round_key = k; inv_r = iv; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0; data = $urandom; round_key = {4{$urandom}}; inv_r = 0;
    chk({name, "_lat1"}, {127'b0, oready}, 128'd0);
    @(posedge clk); #1;
    chk({name, "_lat2"}, {127'b0, oready}, 128'd1);
    chk({name, "_result"}, result, exp);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 0; out_ready = 1;
    while ((q.size() != 0 || oready) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", {96'b0, 32'(q.size())}, 128'd0);
  endtask

  task automatic rand_in();
    data = {$urandom, $urandom, $urandom, $urandom};
    round_key = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_INV_SHIFTROWS_EN
    inv_r = 1'($urandom);
`endif
  endtask

  initial begin
    int a0, o0;
    #2;
    chk("reset_oready", {127'b0, oready}, 128'd0);
    chk("reset_result", result, 128'd0);
    @(posedge clk); #1;
    reset_n = 1;
    chk("reset_iready", {127'b0, iready}, 128'd1);
    @(posedge clk); #1;
    directed("perm", 128'h000102030405060708090a0b0c0d0e0f, 128'h0, 1'b0,
             128'h00050a0f04090e03080d02070c01060b);
    directed("fips", 128'he9098972cb31075f3d327d94af2e2cb5, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0,
             128'h3925841d02dc09fbdc118597196a0b32);
`ifdef AES_INV_SHIFTROWS_EN
    directed("inv", 128'h000102030405060708090a0b0c0d0e0f, 128'h0, 1'b1,
             128'h000d0a0704010e0b0805020f0c090603);
`endif
    // Streaming: eight back-to-back blocks at full rate.
    o0 = n_out;
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; rand_in();
      @(posedge clk); #1;
    end
    drain();
    chk("stream_count", {96'b0, 32'(n_out - o0)}, 128'd8);
    // Back-pressure: only two blocks fit while the output is stalled.
    a0 = n_acc;
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; rand_in();
      @(posedge clk); #1;
    end
    chk("bp_accepts", {96'b0, 32'(n_acc - a0)}, 128'd2);
    chk("bp_iready", {127'b0, iready}, 128'd0);
    drain();
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom); rand_in();
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain();
    chk("total_balance", {96'b0, 32'(n_out)}, {96'b0, 32'(n_acc)});
    // Reset with two blocks in flight.
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; rand_in();
      @(posedge clk); #1;
    end
    in_valid = 0;
    reset_n = 0;
    q.delete();
    #1;
    chk("rst_oready", {127'b0, oready}, 128'd0);
    chk("rst_result", result, 128'd0);
    chk("rst_iready", {127'b0, iready}, 128'd1);
    @(posedge clk); #1;
    reset_n = 1; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_oready", {127'b0, oready}, 128'd0);
    end
    directed("post_rst", 128'h000102030405060708090a0b0c0d0e0f, 128'hffffffffffffffffffffffffffffffff, 1'b0,
             128'hfffaf5f0fbf6f1fcf7f2fdf8f3fef9f4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
